sm_seg_scan_ctrl: RTL and testbench

//  Scan controller for a multiplexed 7-segment display driven through GPIO. Shows DIGITS

---
 rtl/sm_seg_scan_ctrl.sv | 138 +++++++++++++
 tb/tb_sm_seg_scan_ctrl.sv | 173 +++++++++++++++++
 2 files changed

// File: rtl/sm_seg_scan_ctrl.sv
// Scan controller for a multiplexed 7-segment display.
// Time-multiplexes DIGITS digits over one segment bus with one-hot digit enables.
// Segment data is double-buffered: a load fills the pending buffer, and the active
// buffer is only updated at a frame boundary, so a frame never mixes old and new data.
// Optional macro SM_SEG_SCAN_BLANK_EN adds BLANK_CYCLES of dead-time at the start of
// every digit slot to suppress ghosting.
module sm_seg_scan_ctrl #(
   parameter int unsigned DIGITS         = 3,
   parameter int unsigned SCAN_DIV       = 50000,
   parameter int unsigned DIV_WIDTH      = 16,
   parameter bit          SEG_ACTIVE_LOW = 1'b1,
   parameter bit          DIG_ACTIVE_LOW = 1'b1,
   parameter int unsigned BLANK_CYCLES   = 64
) (
   input  logic                  clkIn,
   input  logic                  rst_n,
   input  logic [DIGITS*7-1:0]   seg_in,
   input  logic                  load,
   output logic                  load_ack,
   output logic                  frame_start,
   output logic [6:0]            seg,
   output logic [DIGITS-1:0]     dig_sel
);

   localparam int unsigned IDX_W = $clog2(DIGITS);

   localparam logic [6:0]        SEG_OFF = {7{SEG_ACTIVE_LOW}};
   localparam logic [DIGITS-1:0] DIG_OFF = {DIGITS{DIG_ACTIVE_LOW}};
`ifdef SM_SEG_SCAN_BLANK_EN
   // Digit 0's first slot out of reset is blanked too.
   localparam logic [DIGITS-1:0] DIG_RST = (BLANK_CYCLES > 0) ? DIG_OFF
                                                              : (DIG_OFF ^ DIGITS'(1));
`else
   localparam logic [DIGITS-1:0] DIG_RST = DIG_OFF ^ DIGITS'(1);
`endif

   // Elaboration-time parameter sanity checks.
   if (DIGITS < 2 || DIGITS > 8) begin : g_chk_digits
      $error("sm_seg_scan_ctrl: DIGITS must be 2..8");
   end
   if (SCAN_DIV < 4) begin : g_chk_div
      $error("sm_seg_scan_ctrl: SCAN_DIV must be >= 4");
   end
   if ((64'd1 << DIV_WIDTH) <= 64'(SCAN_DIV - 1)) begin : g_chk_width
      $error("sm_seg_scan_ctrl: DIV_WIDTH too small for SCAN_DIV");
   end
   if (BLANK_CYCLES >= SCAN_DIV) begin : g_chk_blank
      $error("sm_seg_scan_ctrl: BLANK_CYCLES must be < SCAN_DIV");
   end

   logic [DIV_WIDTH-1:0]  r_cnt;
   logic [IDX_W-1:0]      r_idx;
   logic [DIGITS*7-1:0]   r_active;
   logic [DIGITS*7-1:0]   r_pending;
   logic                  r_pend;
   logic                  r_load_ack;
   logic                  r_frame_start;
   logic [6:0]            r_seg;
   logic [DIGITS-1:0]     r_dig_sel;

   logic                  w_tick;
   logic                  w_boundary;
   logic [DIV_WIDTH-1:0]  w_cnt_d;
   logic [IDX_W-1:0]      w_idx_d;
   logic [DIGITS*7-1:0]   w_active_d;
   logic [DIGITS*7-1:0]   w_pending_d;
   logic                  w_pend_d;
   logic                  w_ack_d;
   logic [6:0]            w_seg_d;
   logic [DIGITS-1:0]     w_dig_d;

   // Next-state logic; outputs are derived from next-state so they are registered
   // yet already show the new digit in the cycle after the tick.
   always_comb begin
      w_tick      = (r_cnt == DIV_WIDTH'(SCAN_DIV - 1));
      w_boundary  = w_tick && (r_idx == IDX_W'(DIGITS - 1));
      w_cnt_d     = w_tick ? '0 : r_cnt + 1'b1;
      w_idx_d     = r_idx;
      if (w_tick) begin
         w_idx_d = w_boundary ? '0 : r_idx + 1'b1;
      end

      // A load on the boundary cycle bypasses the pending buffer.
      w_active_d  = r_active;
      w_pending_d = load ? seg_in : r_pending;
      w_pend_d    = load | r_pend;
      w_ack_d     = 1'b0;
      if (w_boundary) begin
         if (load) begin
            w_active_d = seg_in;
         end else if (r_pend) begin
            w_active_d = r_pending;
         end
         w_ack_d  = load | r_pend;
         w_pend_d = 1'b0;
      end

      w_seg_d = w_active_d[int'(w_idx_d) * 7 +: 7] ^ SEG_OFF;
      w_dig_d = (DIGITS'(1) << w_idx_d) ^ DIG_OFF;
`ifdef SM_SEG_SCAN_BLANK_EN
      if (w_cnt_d < DIV_WIDTH'(BLANK_CYCLES)) begin
         w_seg_d = SEG_OFF;
         w_dig_d = DIG_OFF;
      end
`endif
   end

   // State and output registers with synchronous active-low reset.
   always_ff @(posedge clkIn) begin
      if (!rst_n) begin
         r_cnt         <= '0;
         r_idx         <= '0;
         r_active      <= '0;
         r_pending     <= '0;
         r_pend        <= 1'b0;
         r_load_ack    <= 1'b0;
         r_frame_start <= 1'b0;
         r_seg         <= SEG_OFF;
         r_dig_sel     <= DIG_RST;
      end else begin
         r_cnt         <= w_cnt_d;
         r_idx         <= w_idx_d;
         r_active      <= w_active_d;
         r_pending     <= w_pending_d;
         r_pend        <= w_pend_d;
         r_load_ack    <= w_ack_d;
         r_frame_start <= w_boundary;
         r_seg         <= w_seg_d;
         r_dig_sel     <= w_dig_d;
      end
   end

   assign load_ack    = r_load_ack;
   assign frame_start = r_frame_start;
   assign seg         = r_seg;
   assign dig_sel     = r_dig_sel;

endmodule

// File: tb/tb_sm_seg_scan_ctrl.sv
// Directed bench for sm_seg_scan_ctrl (DIGITS=3, SCAN_DIV=4, active-low outputs).
// Build with SM_SEG_SCAN_BLANK_EN defined to exercise the dead-time variant (BLANK_CYCLES=1).
module tb_sm_seg_scan_ctrl;

   logic        clk;
   logic        rst_n;
   logic [20:0] seg_in;
   logic        load;
   logic        load_ack;
   logic        frame_start;
   logic [6:0]  seg;
   logic [2:0]  dig_sel;

   int n_vec;
   int n_err;
   int tb_cnt;   // expected prescaler phase, used for blank-cycle expectations

   sm_seg_scan_ctrl #(
      .DIGITS         (3),
      .SCAN_DIV       (4),
      .DIV_WIDTH      (4),
      .SEG_ACTIVE_LOW (1'b1),
      .DIG_ACTIVE_LOW (1'b1),
      .BLANK_CYCLES   (1)
   ) u_dut (
      .clkIn       (clk),
      .rst_n       (rst_n),
      .seg_in      (seg_in),
      .load        (load),
      .load_ack    (load_ack),
      .frame_start (frame_start),
      .seg         (seg),
      .dig_sel     (dig_sel)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // One clock edge; outputs are sampled 1 time unit after it.
   task automatic cyc();
      logic rst_s;
      rst_s = rst_n;
      @(posedge clk);
      #1;
      if (!rst_s) tb_cnt = 0;
      else        tb_cnt = (tb_cnt == 3) ? 0 : tb_cnt + 1;
   endtask

   task automatic check(input string tag, input int idx, input logic [6:0] eseg_in,
                        input logic eack, input logic efs);
      logic [2:0] edig;
      logic [6:0] eseg;
      eseg = eseg_in;
      case (idx)
         0:       edig = 3'b110;
         1:       edig = 3'b101;
         default: edig = 3'b011;
      endcase
`ifdef SM_SEG_SCAN_BLANK_EN
      if (tb_cnt == 0) begin
         edig = 3'b111;
         eseg = 7'h7F;
      end
`endif
      n_vec++;
      assert ({dig_sel, seg, load_ack, frame_start} === {edig, eseg, eack, efs})
      else begin
         n_err++;
         $error("FAIL %s: got dig=%b seg=%h ack=%b fs=%b, expected dig=%b seg=%h ack=%b fs=%b",
                tag, dig_sel, seg, load_ack, frame_start, edig, eseg, eack, efs);
      end
   endtask

   // n edges within one digit slot; ack/fs expectations apply to the first edge only.
   task automatic edges(input string tag, input int n, input int idx, input logic [6:0] eseg,
                        input logic eack, input logic efs);
      for (int i = 0; i < n; i++) begin
         cyc();
         check(tag, idx, eseg, (i == 0) ? eack : 1'b0, (i == 0) ? efs : 1'b0);
         load = 1'b0;
      end
   endtask

   initial begin
      n_vec  = 0;
      n_err  = 0;
      tb_cnt = 0;

      // 1: reset held 3 cycles with load asserted
      rst_n  = 1'b0;
      load   = 1'b1;
      seg_in = 21'h1FFFFF;
      for (int i = 0; i < 3; i++) begin
         cyc();
         check("reset", 0, 7'h7F, 1'b0, 1'b0);
      end
      rst_n  = 1'b1;
      load   = 1'b0;
      seg_in = '0;

      // 2: free scan, no ack after release
      edges("rst_rel",   3, 0, 7'h7F, 1'b0, 1'b0);
      edges("scan_d1",   4, 1, 7'h7F, 1'b0, 1'b0);
      edges("scan_d2",   4, 2, 7'h7F, 1'b0, 1'b0);
      edges("scan_d0",   4, 0, 7'h7F, 1'b0, 1'b1);
      edges("scan_d1b",  4, 1, 7'h7F, 1'b0, 1'b0);
      edges("scan_d2b",  4, 2, 7'h7F, 1'b0, 1'b0);
      edges("scan_d0b",  4, 0, 7'h7F, 1'b0, 1'b1);

      // 3: mid-frame load during digit-1 slot
      edges("mid_pre",   1, 1, 7'h7F, 1'b0, 1'b0);
      load   = 1'b1;
      seg_in = {7'h06, 7'h5B, 7'h4F};
      edges("mid_ld",    1, 1, 7'h7F, 1'b0, 1'b0);
      seg_in = '0;
      edges("mid_post",  2, 1, 7'h7F, 1'b0, 1'b0);
      edges("mid_d2",    4, 2, 7'h7F, 1'b0, 1'b0);
      edges("mid_new0",  4, 0, 7'h30, 1'b1, 1'b1);
      edges("mid_new1",  4, 1, 7'h24, 1'b0, 1'b0);
      edges("mid_new2",  4, 2, 7'h79, 1'b0, 1'b0);
      edges("mid_noack", 4, 0, 7'h30, 1'b0, 1'b1);

      // 4a: two loads in one frame, last wins, single ack
      edges("dbl_pre",   1, 1, 7'h24, 1'b0, 1'b0);
      load   = 1'b1;
      seg_in = {7'h07, 7'h07, 7'h07};
      edges("dbl_a",     1, 1, 7'h24, 1'b0, 1'b0);
      load   = 1'b1;
      seg_in = {7'h7F, 7'h6D, 7'h66};
      edges("dbl_b",     1, 1, 7'h24, 1'b0, 1'b0);
      seg_in = '0;
      edges("dbl_post",  1, 1, 7'h24, 1'b0, 1'b0);
      edges("dbl_d2",    4, 2, 7'h79, 1'b0, 1'b0);
      edges("dbl_new0",  4, 0, 7'h19, 1'b1, 1'b1);
      edges("dbl_new1",  4, 1, 7'h12, 1'b0, 1'b0);
      edges("dbl_new2",  4, 2, 7'h00, 1'b0, 1'b0);
      edges("dbl_noack", 4, 0, 7'h19, 1'b0, 1'b1);

      // 4b: load on the boundary tick cycle goes straight to active
      edges("co_d1",     4, 1, 7'h12, 1'b0, 1'b0);
      edges("co_d2",     4, 2, 7'h00, 1'b0, 1'b0);
      load   = 1'b1;
      seg_in = {7'h5B, 7'h06, 7'h3F};
      edges("co_new0",   1, 0, 7'h40, 1'b1, 1'b1);
      seg_in = '0;
      edges("co_new0b",  3, 0, 7'h40, 1'b0, 1'b0);
      edges("co_new1",   4, 1, 7'h79, 1'b0, 1'b0);
      edges("co_new2",   4, 2, 7'h24, 1'b0, 1'b0);

      // 5: reset while a load is pending at idx=2
      edges("rm_d0",     4, 0, 7'h40, 1'b0, 1'b1);
      edges("rm_d1",     4, 1, 7'h79, 1'b0, 1'b0);
      edges("rm_d2",     1, 2, 7'h24, 1'b0, 1'b0);
      load   = 1'b1;
      seg_in = {7'h7F, 7'h7F, 7'h7F};
      edges("rm_ld",     1, 2, 7'h24, 1'b0, 1'b0);
      seg_in = '0;
      rst_n  = 1'b0;
      cyc();
      check("rm_rst", 0, 7'h7F, 1'b0, 1'b0);
      rst_n  = 1'b1;
      edges("rm_rel",    3, 0, 7'h7F, 1'b0, 1'b0);
      edges("rm_d1b",    4, 1, 7'h7F, 1'b0, 1'b0);
      edges("rm_d2b",    4, 2, 7'h7F, 1'b0, 1'b0);
      edges("rm_noack",  4, 0, 7'h7F, 1'b0, 1'b1);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
